// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the word packer: the default byte width and
//   bytes-per-word, and the packer FSM state type.
//   No ports (package).
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NBYTES = 4;

  // FILL: collecting bytes from the upstream FIFO.
  // HOLD: presenting a completed (or flushed) word downstream.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Small single-clock FIFO with a registered read port: o_dout carries the
//   popped word in the cycle after a cycle with i_rd_en=1 and o_empty=0.
//   Writes while full and reads while empty are ignored.
// Ports:
//   clk, reset_n          : rising-edge clock, synchronous active-low reset
//   i_wr_en, i_wr_data    : push request and data
//   i_rd_en, o_dout       : pop request and registered read data
//   o_full, o_empty       : occupancy flags
//   o_count               : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_dout;
  assign w_do_wr = i_wr_en && !o_full;
  assign w_do_rd = i_rd_en && !o_empty;

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Reads bytes from an upstream sync_fifo (registered read port) and packs
//   NBYTES of them little-endian into one output word. A single-cycle flush
//   emits a partially filled word with the unused lanes zero.
// Ports:
//   clk, reset_n   : rising-edge clock, synchronous active-low reset
//   fifo_empty     : upstream empty flag
//   fifo_dout      : upstream read data, valid the cycle after a read
//   fifo_rd_en     : upstream read enable
//   flush          : request to emit the bytes collected so far
//   out_ready      : downstream accept
//   out_valid      : out_data/out_bytes are valid
//   out_data       : packed word, first byte in bits [DATA_W-1:0]
//   out_bytes      : number of valid bytes in out_data (1..NBYTES)
//
// Output handshake: a word is transferred on every rising edge where
// out_valid && out_ready; while out_valid=1 and out_ready=0, out_data,
// out_bytes and out_valid stay unchanged. out_valid never depends on
// out_ready.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NBYTES = DEF_NBYTES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fifo_empty,
  input  logic [DATA_W-1:0]        fifo_dout,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W*NBYTES-1:0] out_data,
  output logic [$clog2(NBYTES):0]  out_bytes
);

  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(NBYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  pack_state_t                     r_state;
  pack_state_t                     w_next_state;
  logic [CW-1:0]                   r_byte_cnt;
  logic                            r_pending;
  logic                            r_flush_req;
  logic [NBYTES-1:0][DATA_W-1:0]   r_lanes;

  logic [CW-1:0] w_level;       // bytes captured plus the one in flight
  logic          w_completes;   // the in-flight byte fills the last lane
  logic          w_flush_take;
  logic          w_accept;
  logic          w_to_hold;

  assign w_level     = r_byte_cnt + CW'(r_pending);
  assign w_completes = (r_state == FILL) && r_pending && (r_byte_cnt == LAST_CNT);
  assign w_accept    = (r_state == HOLD) && out_ready;
  assign w_to_hold   = (r_state == FILL) && (w_next_state == HOLD);

  // A flush that coincides with the completing byte is dropped: the full
  // word goes out and nothing is left to flush.
  assign w_flush_take = flush && (r_state == FILL) && (w_level != '0) && !w_completes;

  // Gated with reset_n so the upstream FIFO is never popped while the
  // packer is being reset (the byte would be lost).
  assign fifo_rd_en = reset_n && (r_state == FILL) && !fifo_empty &&
                      (w_level < FULL_CNT) && !r_flush_req;

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_lanes;
  assign out_bytes = (r_state == HOLD) ? r_byte_cnt : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL: begin
        // A pending byte is always captured before a flushed word closes.
        if (w_completes || (r_flush_req && !r_pending)) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= FILL;
      r_byte_cnt  <= '0;
      r_pending   <= 1'b0;
      r_flush_req <= 1'b0;
      r_lanes     <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= fifo_rd_en;

      if (w_accept) begin
        r_byte_cnt <= '0;
        r_lanes    <= '0;
      end else if (r_pending) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (r_byte_cnt == CW'(i)) begin
            r_lanes[i] <= fifo_dout;
          end
        end
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end

      if (w_to_hold) begin
        r_flush_req <= 1'b0;
      end else if (w_flush_take) begin
        r_flush_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Bench for fifo_word_packer fed by a depth-8 sync_fifo. Directed cases
//   cover the fixed vectors; a randomized phase compares every accepted word
//   against the byte stream written into the FIFO.
module tb_fifo_word_packer;

  localparam int DATA_W = 8;
  localparam int NBYTES = 4;
  localparam int WORD_W = DATA_W * NBYTES;

  // clock / reset
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT and upstream FIFO
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [3:0]        fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic [2:0]        out_bytes;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(8)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_rd_en   (fifo_rd_en),
    .o_dout    (fifo_dout),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  fifo_word_packer #(.DATA_W(DATA_W), .NBYTES(NBYTES)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_bytes  (out_bytes)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks (all called at a falling edge, return at a falling edge)
  task automatic write_bytes(input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                             input logic [DATA_W-1:0] b2, input logic [DATA_W-1:0] b3,
                             input int n);
    logic [DATA_W-1:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = bs[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Model: the concatenation of all accepted words' valid bytes equals the
  // byte stream written, in order; unused lanes are zero; a short word needs
  // a flush issued while the packer was filling.
  task automatic score_word(input bit flush_armed);
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] exp;
    int nb;
    nb = int'(out_bytes);
    check("rnd_bytes_range", 32'(nb >= 1 && nb <= NBYTES), 32'd1);
    if (nb < NBYTES) check("rnd_partial_needs_flush", 32'(flush_armed), 32'd1);
    for (int i = 0; i < NBYTES; i++) begin
      lane = out_data[i*DATA_W +: DATA_W];
      if (i < nb) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_byte", 32'd0, 32'd1);
        end else begin
          exp = exp_q.pop_front();
          check("rnd_lane", 32'(lane), 32'(exp));
        end
      end else begin
        check("rnd_zero_lane", 32'(lane), 32'd0);
      end
    end
  endtask

  initial begin
    int bad;
    int sent;
    bit flush_armed;
    bit held;
    logic [WORD_W-1:0] held_data;
    logic [2:0]        held_bytes;

    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_bytes", 32'(out_bytes), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // full word, downstream always ready; valid for exactly one cycle
    out_ready = 1'b1;
    write_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4);
    wait_valid("t030_wait");
    check("t030_data",  out_data, 32'h44332211);
    check("t030_bytes", 32'(out_bytes), 32'd4);
    @(negedge clk);
    check("t030_one_cycle", 32'(out_valid), 32'd0);

    // backpressure: word held, no reads, FIFO keeps the remaining four
    out_ready = 1'b0;
    write_bytes(8'h01, 8'h02, 8'h03, 8'h04, 4);
    write_bytes(8'h05, 8'h06, 8'h07, 8'h08, 4);
    wait_valid("t031_wait1");
    check("t031_data1", out_data, 32'h04030201);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_data !== 32'h04030201 || out_valid !== 1'b1 ||
          out_bytes !== 3'd4 || fifo_rd_en !== 1'b0) bad++;
    end
    check("t031_stable", 32'(bad), 32'd0);
    check("t031_fifo_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    wait_valid("t031_wait2");
    check("t031_data2",  out_data, 32'h08070605);
    check("t031_bytes2", 32'(out_bytes), 32'd4);
    @(negedge clk);

    // flush with two bytes collected and nothing in flight
    write_bytes(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
    repeat (6) @(negedge clk);
    pulse_flush();
    wait_valid("t032_wait");
    check("t032_data",  out_data, 32'h0000BBAA);
    check("t032_bytes", 32'(out_bytes), 32'd2);
    @(negedge clk);

    // flush while the read of 8'hCC is in flight, one byte already held
    write_bytes(8'h01, 8'h00, 8'h00, 8'h00, 1);
    repeat (5) @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hCC;
    @(negedge clk);
    wr_en = 1'b0;
    check("t033_rd_issued", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    pulse_flush();
    wait_valid("t033_wait");
    check("t033_data",  out_data, 32'h0000CC01);
    check("t033_bytes", 32'(out_bytes), 32'd2);
    @(negedge clk);

    // flush with nothing collected is ignored
    check("t034_fifo_empty", 32'(fifo_empty), 32'd1);
    pulse_flush();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
      @(negedge clk);
    end
    check("t034_ignored", 32'(bad), 32'd0);

    // reset mid-word discards the collected and in-flight bytes
    write_bytes(8'h01, 8'h02, 8'h03, 8'h00, 3);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t035_valid", 32'(out_valid), 32'd0);
    check("t035_data",  out_data, 32'd0);
    check("t035_bytes", 32'(out_bytes), 32'd0);
    check("t035_rd_en", 32'(fifo_rd_en), 32'd0);
    write_bytes(8'h05, 8'h06, 8'h07, 8'h08, 4);
    wait_valid("t035_wait");
    check("t035_word", out_data, 32'h08070605);
    check("t035_word_bytes", 32'(out_bytes), 32'd4);
    @(negedge clk);

    // randomized traffic against the byte-stream model
    exp_q.delete();
    sent        = 0;
    flush_armed = 1'b0;
    held        = 1'b0;
    held_data   = '0;
    held_bytes  = '0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      bit draining;
      draining = (sent >= 300);
      if (draining && exp_q.size() == 0 && !out_valid) break;
      if (held) begin
        check("rnd_hold_valid", 32'(out_valid), 32'd1);
        check("rnd_hold_data",  out_data, held_data);
        check("rnd_hold_bytes", 32'(out_bytes), 32'(held_bytes));
      end
      check("rnd_rd_rule", 32'(fifo_rd_en & (fifo_empty | out_valid)), 32'd0);

      if (draining) begin
        out_ready = 1'b1;
        flush     = ((cyc % 6) == 0);
        wr_en     = 1'b0;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 19) == 0);
        if (!fifo_full && $urandom_range(0, 2) != 0) begin
          wr_en   = 1'b1;
          wr_data = DATA_W'($urandom);
          exp_q.push_back(wr_data);
          sent++;
        end else begin
          wr_en = 1'b0;
        end
      end
      if (flush && !out_valid) flush_armed = 1'b1;

      if (out_valid && out_ready) begin
        score_word(flush_armed);
        flush_armed = 1'b0;
        held        = 1'b0;
      end else begin
        held       = out_valid;
        held_data  = out_data;
        held_bytes = out_bytes;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    flush = 1'b0;
    check("rnd_all_sent", 32'(sent), 32'd300);
    check("rnd_drained",  32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
